// File: rtl/ad9866_gain_sched.sv
// AD9866 gain-write scheduler: tracks host RX/TX gain changes and issues
// one engine request at a time, gated by init holdoff and settle gap.
module ad9866_gain_sched #(
    parameter int GAIN_W         = 6,
    parameter int INIT_HOLDOFF   = 2048,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GAIN_W-1:0] rx_gain_in,
    input  logic [GAIN_W-1:0] tx_gain_in,
    input  logic              ptt,
    input  logic              force_resend,
    input  logic              sen_n,
    output logic              ext_rx_rqst,
    output logic [GAIN_W-1:0] rx_gain,
    output logic              ext_tx_rqst,
    output logic [GAIN_W-1:0] tx_gain,
    output logic              busy,
    output logic              err_timeout,
    output logic [7:0]        write_count
);

    typedef enum logic [2:0] {
        S_HOLDOFF,
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_GAP
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(INIT_HOLDOFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rx_rqst_q, rx_rqst_d;
    logic              tx_rqst_q, tx_rqst_d;
    logic [GAIN_W-1:0] rx_gain_q, rx_gain_d;
    logic [GAIN_W-1:0] tx_gain_q, tx_gain_d;
    logic [GAIN_W-1:0] rx_sent_q, rx_sent_d;
    logic [GAIN_W-1:0] tx_sent_q, tx_sent_d;
    logic              rx_pend_q, rx_pend_d;
    logic              tx_pend_q, tx_pend_d;
    logic              sel_tx_q, sel_tx_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              cmp_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_rqst_d = rx_rqst_q;
        tx_rqst_d = tx_rqst_q;
        rx_gain_d = rx_gain_q;
        tx_gain_d = tx_gain_q;
        rx_sent_d = rx_sent_q;
        tx_sent_d = tx_sent_q;
        sel_tx_d  = sel_tx_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;

        cmp_en    = (state_q == S_IDLE) || (state_q == S_GAP);
        rx_pend_d = rx_pend_q | force_resend |
                    (cmp_en && (rx_gain_in != rx_sent_q));
        tx_pend_d = tx_pend_q | force_resend |
                    (cmp_en && (tx_gain_in != tx_sent_q));

        unique case (state_q)
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (tx_pend_q && (ptt || !rx_pend_q)) begin
                    state_d   = S_REQ;
                    sel_tx_d  = 1'b1;
                    tx_rqst_d = 1'b1;
                    tx_gain_d = tx_gain_in;
                end else if (rx_pend_q) begin
                    state_d   = S_REQ;
                    sel_tx_d  = 1'b0;
                    rx_rqst_d = 1'b1;
                    rx_gain_d = rx_gain_in;
                end
            end
            S_REQ: begin
                if (!sen_n) begin
                    state_d   = S_BUSY;
                    rx_rqst_d = 1'b0;
                    tx_rqst_d = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == TMO_LAST) begin
                    // pending flag stays set so IDLE reissues the write
                    state_d   = S_IDLE;
                    rx_rqst_d = 1'b0;
                    tx_rqst_d = 1'b0;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BUSY: begin
                if (sen_n) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    wcnt_d  = wcnt_q + 8'd1;
                    if (sel_tx_q) begin
                        tx_sent_d = tx_gain_q;
                        tx_pend_d = force_resend;
                    end else begin
                        rx_sent_d = rx_gain_q;
                        rx_pend_d = force_resend;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_HOLDOFF;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE) || rx_pend_d || tx_pend_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HOLDOFF;
            cnt_q     <= '0;
            rx_rqst_q <= 1'b0;
            tx_rqst_q <= 1'b0;
            rx_gain_q <= '0;
            tx_gain_q <= '0;
            rx_sent_q <= '0;
            tx_sent_q <= '0;
            rx_pend_q <= 1'b1;
            tx_pend_q <= 1'b1;
            sel_tx_q  <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_rqst_q <= rx_rqst_d;
            tx_rqst_q <= tx_rqst_d;
            rx_gain_q <= rx_gain_d;
            tx_gain_q <= tx_gain_d;
            rx_sent_q <= rx_sent_d;
            tx_sent_q <= tx_sent_d;
            rx_pend_q <= rx_pend_d;
            tx_pend_q <= tx_pend_d;
            sel_tx_q  <= sel_tx_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign ext_rx_rqst = rx_rqst_q;
    assign ext_tx_rqst = tx_rqst_q;
    assign rx_gain     = rx_gain_q;
    assign tx_gain     = tx_gain_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign write_count = wcnt_q;

    ap_one_rqst: assert property (@(posedge clk) disable iff (!reset_n)
        !(rx_rqst_q && tx_rqst_q));

endmodule

// File: tb/tb_ad9866_gain_sched.sv
// Directed bench for ad9866_gain_sched with a small SPI engine model
// and a request scoreboard.
module tb_ad9866_gain_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] rx_gain_in, tx_gain_in;
    logic       ptt, force_resend, sen_n;
    logic       ext_rx_rqst, ext_tx_rqst;
    logic [5:0] rx_gain, tx_gain;
    logic       busy, err_timeout;
    logic [7:0] write_count;

    ad9866_gain_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_gain_in   (rx_gain_in),
        .tx_gain_in   (tx_gain_in),
        .ptt          (ptt),
        .force_resend (force_resend),
        .sen_n        (sen_n),
        .ext_rx_rqst  (ext_rx_rqst),
        .rx_gain      (rx_gain),
        .ext_tx_rqst  (ext_tx_rqst),
        .tx_gain      (tx_gain),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .write_count  (write_count)
    );

    typedef struct packed {
        logic       tx;
        logic [5:0] g;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         eng_en = 1'b1;
    int         eng_cnt = 0;
    int         release_cyc = 0;
    bit         hold_chk = 1'b0;
    int         last_done_cyc = -1;
    int         req_len = 0;
    int         last_req_len = 0;
    int         err_pulses = 0;
    logic [7:0] prev_wc = 8'd0;
    logic       prev_rx = 1'b0;
    logic       prev_tx = 1'b0;
    logic [5:0] held_g = 6'd0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic tx, input logic [5:0] g);
        exp_t e;
        e.tx = tx;
        e.g  = g;
        return e;
    endfunction

    // Engine model: 2 cycles after a request, hold sen_n low 8 cycles
    initial begin
        sen_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n || !eng_en) begin
                eng_cnt = 0;
                sen_n   = 1'b1;
            end else if (eng_cnt == 0) begin
                if (ext_rx_rqst || ext_tx_rqst) eng_cnt = 1;
            end else begin
                eng_cnt++;
                sen_n = (eng_cnt < 3) || (eng_cnt > 10);
                if (eng_cnt > 10) eng_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new request
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            prev_rx = 1'b0;
            prev_tx = 1'b0;
            prev_wc = 8'd0;
            req_len = 0;
        end else begin
            logic rq, rise;
            logic [5:0] g;
            exp_t e;
            rq   = ext_rx_rqst | ext_tx_rqst;
            rise = (ext_rx_rqst & !prev_rx) | (ext_tx_rqst & !prev_tx);
            g    = ext_tx_rqst ? tx_gain : rx_gain;
            if (rq) chk("overlap", int'(ext_rx_rqst & ext_tx_rqst), 0);
            if (rise) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: tx=%0d gain=%0d none expected",
                             ext_tx_rqst, g);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_chan", int'(ext_tx_rqst), int'(e.tx));
                    chk("req_gain", int'(g), int'(e.g));
                end
                held_g = g;
                if (hold_chk) begin
                    chk("holdoff", int'((cyc - release_cyc) >= 2048), 1);
                    hold_chk = 1'b0;
                end else if (last_done_cyc >= 0) begin
                    chk("settle_gap", int'((cyc - last_done_cyc) >= 16), 1);
                end
            end else if (rq) begin
                chk("gain_hold", int'(g), int'(held_g));
            end
            if (rq) begin
                req_len++;
            end else if (req_len > 0) begin
                last_req_len = req_len;
                req_len      = 0;
            end
            if (err_timeout) err_pulses++;
            if (write_count != prev_wc) last_done_cyc = cyc;
            prev_wc = write_count;
            prev_rx = ext_rx_rqst;
            prev_tx = ext_tx_rqst;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk(name, int'(i < budget), 1);
    endtask

    task automatic wait_sen_low(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!sen_n) break;
        end
        chk(name, int'(i < budget), 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_rqst"}, int'(ext_rx_rqst), 0);
        chk({tag, "_tx_rqst"}, int'(ext_tx_rqst), 0);
        chk({tag, "_rx_gain"}, int'(rx_gain), 0);
        chk({tag, "_tx_gain"}, int'(tx_gain), 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_wc"}, int'(write_count), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n     = 1'b1;
        release_cyc = cyc;
        hold_chk    = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        rx_gain_in   = 6'h2A;
        tx_gain_in   = 6'h10;
        ptt          = 1'b0;
        force_resend = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");

        // power-up: RX then TX after holdoff
        exp_q.push_back(mk(1'b0, 6'h2A));
        exp_q.push_back(mk(1'b1, 6'h10));
        release_reset();
        wait_idle(5000, "t1_done");
        chk("t1_wc", int'(write_count), 2);

        // ptt gives TX priority on a simultaneous change
        ptt = 1'b1;
        exp_q.push_back(mk(1'b1, 6'h3F));
        exp_q.push_back(mk(1'b0, 6'h05));
        rx_gain_in = 6'h05;
        tx_gain_in = 6'h3F;
        wait_idle(500, "t2_done");
        chk("t2_wc", int'(write_count), 4);
        ptt = 1'b0;

        // input changes during BUSY: only final value rewritten
        exp_q.push_back(mk(1'b0, 6'h01));
        exp_q.push_back(mk(1'b0, 6'h03));
        rx_gain_in = 6'h01;
        wait_sen_low(100, "t3_sen_low");
        rx_gain_in = 6'h02;
        repeat (2) @(negedge clk);
        rx_gain_in = 6'h03;
        wait_idle(500, "t3_done");
        chk("t3_wc", int'(write_count), 6);

        // engine stuck: timeout then reissue
        eng_en = 1'b0;
        exp_q.push_back(mk(1'b0, 6'h11));
        exp_q.push_back(mk(1'b0, 6'h11));
        rx_gain_in = 6'h11;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (err_pulses > 0) break;
        end
        @(negedge clk);
        chk("t4_err_seen", err_pulses, 1);
        chk("t4_req_len", last_req_len, 1024);
        chk("t4_wc_hold", int'(write_count), 6);
        eng_en = 1'b1;
        wait_idle(500, "t4_done");
        chk("t4_wc", int'(write_count), 7);
        chk("t4_err_once", err_pulses, 1);

        // force_resend rewrites both current values
        exp_q.push_back(mk(1'b0, 6'h11));
        exp_q.push_back(mk(1'b1, 6'h3F));
        force_resend = 1'b1;
        @(negedge clk);
        force_resend = 1'b0;
        wait_idle(500, "t5_done");
        chk("t5_wc", int'(write_count), 9);

        // reset during BUSY
        exp_q.push_back(mk(1'b0, 6'h22));
        rx_gain_in = 6'h22;
        wait_sen_low(100, "t6_sen_low");
        #2 reset_n = 1'b0;
        #1 check_reset("t6_rst");
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(1'b0, 6'h22));
        exp_q.push_back(mk(1'b1, 6'h3F));
        release_reset();
        wait_idle(5000, "t6_done");
        chk("t6_wc", int'(write_count), 2);
        chk("t6_err", err_pulses, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9866_gain_sched.md
Name: ad9866_gain_sched

Overview:
- Upstream scheduler that feeds the AD9866 SPI configuration engine's external gain-write request inputs (ext_rx_rqst/rx_gain, ext_tx_rqst/tx_gain).
- Tracks host RX/TX gain settings and detects changes against the last value actually written.
- Issues one request at a time, holding gain data stable until the SPI transaction starts and completes, as observed on sen_n.
- Guarantees no request overlaps the engine's power-up init sequence and never asserts both requests together.

Parameters:
- GAIN_W, 6, gain code width (matches engine rx_gain/tx_gain).
- INIT_HOLDOFF, 2048, cycles after reset before any request (covers engine init sequence).
- SETTLE_CYCLES, 16, idle gap after each completed transaction before the next request.
- TIMEOUT_CYCLES, 1024, max cycles a request may wait for sen_n to fall.

Ports:
- clk  in  1  system clock, shared with SPI engine.
- reset_n  in  1  asynchronous active-low reset.
- rx_gain_in  in  GAIN_W  host RX gain setting.
- tx_gain_in  in  GAIN_W  host TX gain setting.
- ptt  in  1  transmit active; selects priority.
- force_resend  in  1  single-cycle pulse; marks both RX and TX pending.
- sen_n  in  1  SPI enable from engine (0 = transaction in progress).
- ext_rx_rqst  out  1  RX gain write request to engine.
- rx_gain  out  GAIN_W  RX gain code to engine.
- ext_tx_rqst  out  1  TX gain write request to engine.
- tx_gain  out  GAIN_W  TX gain code to engine.
- busy  out  1  high in HOLDOFF/REQ/BUSY/GAP.
- err_timeout  out  1  one-cycle pulse on request timeout.
- write_count  out  8  completed gain writes, wraps 255->0.

Behaviour:
- Reset (async, reset_n=0): state HOLDOFF, both requests 0, rx_gain/tx_gain 0, busy 1, err_timeout 0, write_count 0, rx_sent/tx_sent 0, both pending flags set.
- Pending flags: rx_pend is set when rx_gain_in != rx_sent, or on force_resend; tx likewise. Evaluated every cycle in IDLE and GAP.
- HOLDOFF: count INIT_HOLDOFF cycles, then go to IDLE. Requests stay 0 throughout; force_resend is accepted and sets both flags.
- IDLE: busy=0 when no flag is pending.
  - Selection: if ptt=1 and tx_pend, choose TX; else if rx_pend, choose RX; else if tx_pend, choose TX.
  - On selection: snapshot the chosen *_gain_in into the matching output register, assert the matching ext_*_rqst next cycle, and enter REQ.
- REQ:
  - Exactly one request asserted; its gain output is held constant.
  - Next state:
    - If sen_n=0, enter BUSY and deassert the request on that same registered edge (request high for at most 1 cycle after sen_n falls).
    - Else if the timeout counter reaches TIMEOUT_CYCLES-1: deassert, pulse err_timeout, return to IDLE with the pending flag still set.
- BUSY: wait for sen_n=1. Then set *_sent to the snapshot, increment write_count, enter GAP.
- GAP: count SETTLE_CYCLES, then go to IDLE. Flags may be set during GAP but no request is issued.
- Gain outputs hold their last snapshot outside REQ; they change only on a new selection.
- Input change during REQ/BUSY: the snapshot is unaffected. After completion the compare re-arms pending, so exactly one further write occurs with the final value.
- ext_rx_rqst and ext_tx_rqst are never high in the same cycle. This is a required assertion.
- Simultaneous force_resend and completion: force wins; both flags end up set.
- Reset mid-operation: immediate return to reset values. The engine re-runs its own init in parallel, and HOLDOFF protects it.

Test Plan:
- Reset release, rx_gain_in=0x2A, tx_gain_in=0x10, ptt=0, sen_n modelled by the engine: no request for 2048 cycles. Then RX write 0x2A, then TX write 0x10 at least 16 cycles later. write_count=2. Requests never overlap.
- Idle, ptt=1, change both inputs in the same cycle (rx 0x05, tx 0x3F): TX request first with tx_gain=0x3F, RX second. write_count +2.
- Change rx_gain_in 0x01->0x02->0x03 while the first write is in BUSY: exactly two RX writes (0x01, then 0x03). 0x02 is never driven.
- Hold sen_n=1 permanently after a change: request high for 1024 cycles, err_timeout pulses once, request re-issues after return to IDLE. write_count unchanged.
- force_resend pulse with no input change: one RX and one TX write of the current values.
- Assert reset_n=0 during BUSY: all outputs return to reset values asynchronously. After release, 2048-cycle holdoff, then both values rewritten.
